mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
Shares the core's single memory bus (mem_valid/mem_ready/mem_instr/mem_addr/mem_wdata/mem_wstrb/mem_rdata) between an instruction-fetch requester and a data load/store requester. Data has priority, with a starvation cap that protects fetch. A watchdog aborts bus transactions that stall too long. It sits between the fetch/LSU logic and the external memory/bus, and presents the same valid/ready contract the formal memory checks already use.

Parameters:
TIMEOUT, 16, max cycles mem_valid may wait for mem_ready before abort; 0 disables the watchdog.
MAX_DATA_STREAK, 4, max consecutive data grants while fetch is pending; >=1.

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  asynchronous, active-high reset
i_valid  in  1  fetch request; held until i_ready
i_addr  in  32  fetch address, word-aligned
i_ready  out  1  fetch completion pulse
i_rdata  out  32  fetch data; valid only when i_ready=1
i_err  out  1  fetch aborted by timeout; qualified by i_ready
d_valid  in  1  data request; held until d_ready
d_addr  in  32  data address
d_wdata  in  32  store data
d_wstrb  in  4  byte strobes; 0 means load
d_ready  out  1  data completion pulse
d_rdata  out  32  load data; valid only when d_ready=1
d_err  out  1  data aborted by timeout; qualified by d_ready
mem_valid  out  1  bus request
mem_instr  out  1  1 = fetch transaction
mem_addr  out  32  bus address
mem_wdata  out  32  bus store data
mem_wstrb  out  4  bus strobes
mem_ready  in  1  bus completion
mem_rdata  in  32  bus read data

Behaviour:
- FSM states: IDLE, BUSY_I, BUSY_D. Reset gives IDLE, mem_valid=0, mem_instr=0, mem_addr/wdata/wstrb=0, streak=0, watchdog=0.
- Reset is asynchronous. Asserting reset mid-transaction drops mem_valid at once, with no requester ready pulse.
- IDLE arbitration, evaluated every cycle:
  - Only d_valid: grant data.
  - Only i_valid: grant fetch.
  - Both: grant data unless streak==MAX_DATA_STREAK, in which case grant fetch.
- Grant actions:
  - Fetch grant: register i_addr, wdata=0, wstrb=0, mem_instr=1. Go to BUSY_I.
  - Data grant: register d_addr/d_wdata/d_wstrb, mem_instr=0. Go to BUSY_D.
- Streak counter: increments on a data grant when i_valid=1, saturating at MAX_DATA_STREAK. Clears on any fetch grant, and on a data grant while i_valid=0.
- Latency: request seen in IDLE at cycle N gives mem_valid=1 at N+1. mem_valid and all bus fields stay stable until completion.
- Completion: at cycle M with mem_ready=1 in BUSY_x:
  - The granted requester's ready is 1 combinationally in cycle M.
  - rdata = mem_rdata, err=0.
  - State goes to IDLE at M+1 with mem_valid=0.
  - There is one mandatory idle bubble, so the earliest next mem_valid is M+2.
- Ready outputs: never asserted outside BUSY_x, and never both in one cycle. i_rdata/d_rdata pass mem_rdata through unconditionally.
- Watchdog:
  - Counts cycles with mem_valid=1 && mem_ready=0; clears on IDLE.
  - When the count reaches TIMEOUT with mem_ready still 0, the granted ready and err pulse for that cycle with rdata forced to 0. State goes to IDLE next cycle.
  - If mem_ready=1 in the same cycle the count reaches TIMEOUT, it is a normal completion with err=0.
- A requester dropping valid while granted is a protocol violation. The transaction still completes and the ready pulse is still issued.
- Ready is not registered. No combinational path from mem_ready to mem_valid.

Test Plan:
- Single fetch: i_valid=1, i_addr=0x100 at cycle 0; mem_ready=1 at cycle 3 with mem_rdata=0x00000013 -> mem_valid/mem_instr=1 cycles 1-3, mem_addr=0x100, i_ready=1 and i_rdata=0x13 cycle 3, mem_valid=0 cycle 4.
- Simultaneous requests: i_valid and d_valid=1 (d_addr=0x2000, d_wstrb=0xF, d_wdata=0xDEADBEEF), zero-wait memory -> data granted first (mem_instr=0, wstrb=0xF), then fetch granted after the bubble.
- Starvation: i_valid held, d_valid re-asserted each time, MAX_DATA_STREAK=4 -> exactly 4 data transactions, then a fetch transaction, then the streak restarts from 0.
- Timeout: TIMEOUT=16, mem_ready held 0 on a data load -> d_ready=1, d_err=1, d_rdata=0 on the 17th mem_valid cycle; mem_valid=0 the next cycle. Repeat with mem_ready=1 on that cycle -> d_err=0.
- Reset mid-operation: reset asserted in cycle 2 of BUSY_I -> mem_valid=0 in the same cycle with no i_ready. After release the FSM is in IDLE and re-arbitrates.
- Back-to-back fetches with 0-wait memory -> mem_valid pattern 1,0,1,0; bus fields stable while mem_valid=1; i_ready never coincides with d_ready.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory bus between instruction fetch and data load/store requesters.
// Ports:
//   clk, reset         clock; asynchronous active-high reset
//   i_valid/i_addr     fetch request (held until i_ready)
//   i_ready/i_rdata    fetch completion pulse and read data
//   i_err              fetch aborted by watchdog, qualified by i_ready
//   d_valid/d_addr     data request (held until d_ready)
//   d_wdata/d_wstrb    store data and byte strobes (wstrb 0 = load)
//   d_ready/d_rdata    data completion pulse and read data
//   d_err              data aborted by watchdog, qualified by d_ready
//   mem_*              shared bus: valid/instr/addr/wdata/wstrb out, ready/rdata in
module mem_port_arbiter #(
    parameter int TIMEOUT         = 16,
    parameter int MAX_DATA_STREAK = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_valid,
    input  logic [31:0] i_addr,
    output logic        i_ready,
    output logic [31:0] i_rdata,
    output logic        i_err,
    input  logic        d_valid,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [3:0]  d_wstrb,
    output logic        d_ready,
    output logic [31:0] d_rdata,
    output logic        d_err,
    output logic        mem_valid,
    output logic        mem_instr,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata
);
    typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;
    state_t state, state_nx;
    logic [31:0] wdog, streak;
    logic abort, done, grant_i, grant_d;

    // wdog holds the number of stalled cycles already seen, so the abort lands on stall cycle TIMEOUT+1
    assign abort = state != IDLE && !mem_ready && TIMEOUT != 0 && wdog == 32'(TIMEOUT);
    assign done = state != IDLE && (mem_ready || abort);
    assign grant_d = state == IDLE && d_valid && !(i_valid && streak == 32'(MAX_DATA_STREAK));
    assign grant_i = state == IDLE && i_valid && !grant_d;
    assign mem_valid = state != IDLE;

    always_ff @(posedge clk or posedge reset)
        if (reset) state <= IDLE;
        else state <= state_nx;

    always_comb begin
        state_nx = grant_d ? BUSY_D : grant_i ? BUSY_I : done ? IDLE : state;
        i_ready = state == BUSY_I && done;
        d_ready = state == BUSY_D && done;
        i_err = state == BUSY_I && abort;
        d_err = state == BUSY_D && abort;
        i_rdata = abort ? '0 : mem_rdata;
        d_rdata = abort ? '0 : mem_rdata;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wdog <= '0;
            streak <= '0;
            mem_instr <= 1'b0;
            mem_addr <= '0;
            mem_wdata <= '0;
            mem_wstrb <= '0;
        end else begin
            wdog <= (state != IDLE && !done) ? wdog + 32'd1 : '0;
            if (grant_i) begin
                mem_instr <= 1'b1;
                mem_addr <= i_addr;
                mem_wdata <= '0;
                mem_wstrb <= '0;
                streak <= '0;
            end else if (grant_d) begin
                mem_instr <= 1'b0;
                mem_addr <= d_addr;
                mem_wdata <= d_wdata;
                mem_wstrb <= d_wstrb;
                // a data grant with fetch pending can only happen below the cap, so no explicit saturation
                streak <= i_valid ? streak + 32'd1 : '0;
            end
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed and randomized checks of mem_port_arbiter against a transaction-level model.
module tb_mem_port_arbiter;
    localparam int TO = 16;
    localparam int MDS = 4;

    logic        clk = 0, reset = 1;
    logic        i_valid = 0, d_valid = 0, mem_ready = 0;
    logic [31:0] i_addr = 0, d_addr = 0, d_wdata = 0, mem_rdata = 0;
    logic [3:0]  d_wstrb = 0;
    logic        i_ready, i_err, d_ready, d_err, mem_valid, mem_instr;
    logic [31:0] i_rdata, d_rdata, mem_addr, mem_wdata;
    logic [3:0]  mem_wstrb;

    int checks = 0, failures = 0;

    // model: who owns the bus (0 none, 1 fetch, 2 data), what it asked for, how long it has waited
    int          owner = 0, waited = 0, streak = 0;
    logic        e_instr = 0;
    logic [31:0] e_addr = 0, e_wdata = 0;
    logic [3:0]  e_wstrb = 0;
    logic        i_seen = 0, d_seen = 0;

    mem_port_arbiter #(.TIMEOUT(TO), .MAX_DATA_STREAK(MDS)) dut (
        .clk(clk), .reset(reset),
        .i_valid(i_valid), .i_addr(i_addr), .i_ready(i_ready), .i_rdata(i_rdata), .i_err(i_err),
        .d_valid(d_valid), .d_addr(d_addr), .d_wdata(d_wdata), .d_wstrb(d_wstrb),
        .d_ready(d_ready), .d_rdata(d_rdata), .d_err(d_err),
        .mem_valid(mem_valid), .mem_instr(mem_instr), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_ready(mem_ready), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got 0x%08h expected 0x%08h", name, $time, act, exp);
        end
    endtask

    // compare against the model mid-cycle, advance the model, then return just after the next rising edge
    task automatic tick();
        logic tmo, fin, ei, ed;
        @(negedge clk);
        if (reset) begin
            chk("rst_mem_valid", mem_valid, 0);
            chk("rst_mem_instr", mem_instr, 0);
            chk("rst_mem_addr", mem_addr, 0);
            chk("rst_mem_wdata", mem_wdata, 0);
            chk("rst_mem_wstrb", mem_wstrb, 0);
            chk("rst_i_ready", i_ready, 0);
            chk("rst_d_ready", d_ready, 0);
            owner = 0;
            waited = 0;
            streak = 0;
            i_seen = 0;
            d_seen = 0;
        end else begin
            tmo = owner != 0 && !mem_ready && TO != 0 && waited == TO;
            fin = owner != 0 && (mem_ready || tmo);
            ei = owner == 1 && fin;
            ed = owner == 2 && fin;
            chk("mem_valid", mem_valid, owner != 0);
            if (owner != 0) begin
                chk("mem_instr", mem_instr, e_instr);
                chk("mem_addr", mem_addr, e_addr);
                chk("mem_wdata", mem_wdata, e_wdata);
                chk("mem_wstrb", mem_wstrb, e_wstrb);
            end
            chk("i_ready", i_ready, ei);
            chk("d_ready", d_ready, ed);
            if (ei) begin
                chk("i_rdata", i_rdata, tmo ? 0 : mem_rdata);
                chk("i_err", i_err, tmo);
            end
            if (ed) begin
                chk("d_rdata", d_rdata, tmo ? 0 : mem_rdata);
                chk("d_err", d_err, tmo);
            end
            i_seen = ei;
            d_seen = ed;
            if (owner != 0) begin
                waited = fin ? 0 : waited + 1;
                if (fin) owner = 0;
            end else if (d_valid && !(i_valid && streak == MDS)) begin
                owner = 2;
                e_instr = 0;
                e_addr = d_addr;
                e_wdata = d_wdata;
                e_wstrb = d_wstrb;
                streak = i_valid ? streak + 1 : 0;
            end else if (i_valid) begin
                owner = 1;
                e_instr = 1;
                e_addr = i_addr;
                e_wdata = 0;
                e_wstrb = 0;
                streak = 0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [9:0] seq;
        int n, b2b;
        logic prev_mv;
        int phase_p;
        int stall;
        repeat (2) tick();
        reset = 0;
        tick();

        // single fetch, ready on the third bus cycle
        i_valid = 1;
        i_addr = 32'h100;
        #2 chk("sf_c0_valid", mem_valid, 0);
        tick();
        #2 chk("sf_c1_valid", mem_valid, 1);
        chk("sf_c1_instr", mem_instr, 1);
        chk("sf_c1_addr", mem_addr, 32'h100);
        tick();
        tick();
        mem_ready = 1;
        mem_rdata = 32'h13;
        #2 chk("sf_c3_iready", i_ready, 1);
        chk("sf_c3_irdata", i_rdata, 32'h13);
        tick();
        i_valid = 0;
        mem_ready = 0;
        #2 chk("sf_c4_valid", mem_valid, 0);
        tick();

        // watchdog: abort on stall, then a completion racing the abort cycle
        for (int r = 0; r < 2; r++) begin
            d_valid = 1;
            d_addr = 32'h40;
            d_wstrb = 0;
            d_wdata = 0;
            tick();
            for (int k = 1; k < 17; k++) tick();
            mem_rdata = 32'hCAFE0001;
            mem_ready = (r == 1);
            #2 chk("to_dready", d_ready, 1);
            chk("to_derr", d_err, r == 0);
            chk("to_drdata", d_rdata, r == 0 ? 32'h0 : 32'hCAFE0001);
            tick();
            d_valid = 0;
            mem_ready = 0;
            #2 chk("to_after_valid", mem_valid, 0);
            tick();
        end

        // both requesters always asking with zero-wait memory: 4 data, 1 fetch, repeat
        mem_ready = 1;
        d_valid = 1;
        d_addr = 32'h2000;
        d_wstrb = 4'hF;
        d_wdata = 32'hDEADBEEF;
        i_valid = 1;
        i_addr = 32'h300;
        seq = 0;
        n = 0;
        b2b = 0;
        prev_mv = 0;
        for (int c = 0; c < 40 && n < 10; c++) begin
            #2;
            if (mem_valid) begin
                seq = {seq[8:0], mem_instr};
                n++;
                if (n == 1) begin
                    chk("sim_first_instr", mem_instr, 0);
                    chk("sim_first_wstrb", mem_wstrb, 4'hF);
                    chk("sim_first_addr", mem_addr, 32'h2000);
                end
                if (prev_mv) b2b++;
            end
            prev_mv = mem_valid;
            tick();
        end
        chk("streak_grants", n, 10);
        chk("streak_seq", {22'b0, seq}, 32'b0000100001);
        chk("bubble", b2b, 0);
        d_valid = 0;
        i_valid = 0;
        mem_ready = 0;
        repeat (3) tick();

        // reset on the second cycle of a fetch transaction
        i_valid = 1;
        i_addr = 32'h500;
        tick();
        tick();
        mem_ready = 1;
        reset = 1;
        #2 chk("rmid_valid", mem_valid, 0);
        chk("rmid_iready", i_ready, 0);
        tick();
        reset = 0;
        mem_ready = 0;
        #2 chk("rrel_valid", mem_valid, 0);
        tick();
        #2 chk("rearb_valid", mem_valid, 1);
        chk("rearb_instr", mem_instr, 1);
        tick();
        mem_ready = 1;
        tick();
        i_valid = 0;
        mem_ready = 0;
        tick();

        // randomized traffic with varying memory latency, stalls and occasional resets
        stall = 0;
        for (int c = 0; c < 4000; c++) begin
            phase_p = (c / 500) % 4;
            if (i_seen || !i_valid) begin
                i_valid = i_seen ? ($urandom_range(1, 0) == 1) : ($urandom_range(2, 0) == 0);
                i_addr = {$urandom_range(32'hFFFF, 0), 2'b00};
            end
            if (d_seen || !d_valid) begin
                d_valid = d_seen ? ($urandom_range(1, 0) == 1) : ($urandom_range(2, 0) == 0);
                d_addr = $urandom;
                d_wdata = $urandom;
                d_wstrb = 4'($urandom);
            end
            if (stall == 0 && $urandom_range(60, 0) == 0) stall = $urandom_range(24, 12);
            mem_ready = stall > 0 ? 1'b0 : ($urandom_range(phase_p * 3, 0) == 0);
            if (stall > 0) stall--;
            mem_rdata = $urandom;
            reset = $urandom_range(400, 0) == 0;
            tick();
        end
        reset = 0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
